// File: rtl/bus_transfer_sequencer.sv
// Queues register-to-register move requests and issues one one-hot bus drive plus its load mask per cycle.
// Latency: a request accepted at edge E into an empty queue drives src_out/dst_in from E+1 to E+2.
// Backpressure: req_ready drops when the queue holds DEPTH entries; hold stalls issue but not accepts.
module bus_transfer_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_src,
  input  logic [23:0] req_dst,
  input  logic        hold,
  output logic [23:0] src_out,
  output logic [23:0] dst_in,
  output logic        xfer,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  src;
    logic [23:0] dst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [23:0]     src_out_q, src_out_d;
  logic [23:0]     dst_in_q, dst_in_d;
  logic            xfer_q, xfer_d;
  logic            err_q, err_d;

  logic accept;
  logic req_ok;
  logic push;
  logic pop;

  assign req_ready = (count_q != FULL_CNT);
  assign accept    = req_valid && req_ready;
  // Source codes 24..31 name nothing on the bus, and an empty mask loads nothing.
  assign req_ok    = (req_src < 5'd24) && (req_dst != 24'd0);
  assign push      = accept && req_ok;
  // Pop decision uses the pre-edge count, so an entry pushed this edge issues next edge at the earliest.
  assign pop       = !hold && (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  assign src_out = src_out_q;
  assign dst_in  = dst_in_q;
  assign xfer    = xfer_q;
  assign err     = err_q;
  assign busy    = (count_q != '0) || xfer_q;

  // Next-state for pointers, occupancy and the single-cycle issue registers.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    src_out_d = 24'd0;
    dst_in_d  = 24'd0;
    xfer_d    = 1'b0;
    err_d     = accept && !req_ok;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      src_out_d = 24'd1 << head.src;
      dst_in_d  = head.dst;
      xfer_d    = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state and issue registers; reset truncates any active transfer immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      src_out_q <= 24'd0;
      dst_in_q  <= 24'd0;
      xfer_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      src_out_q <= src_out_d;
      dst_in_q  <= dst_in_d;
      xfer_q    <= xfer_d;
      err_q     <= err_d;
    end
  end

  // Queue storage; contents are qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{src: req_src, dst: req_dst};
    end
  end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
module tb_bus_transfer_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [23:0] req_dst;
  logic        hold;
  logic [23:0] src_out;
  logic [23:0] dst_in;
  logic        xfer;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_q[$];
  logic        err_exp = 1'b0;

  bus_transfer_sequencer #(.DEPTH(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .hold      (hold),
    .src_out   (src_out),
    .dst_in    (dst_in),
    .xfer      (xfer),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard: expectations pushed when an accept is seen, popped when xfer appears.
  always @(negedge clk) begin
    logic [47:0] e;
    logic [23:0] oh;
    if (clr) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      total++;
      if (!$onehot0(src_out)) begin
        bad++;
        $display("FAIL onehot src_out=%h required one-hot or zero", src_out);
      end
      total++;
      if (err !== err_exp) begin
        bad++;
        $display("FAIL err_pulse err=%b required %b at %0t", err, err_exp, $time);
      end
      if (xfer === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL stray_xfer src_out=%h dst_in=%h required no transfer", src_out, dst_in);
        end else begin
          e = exp_q.pop_front();
          if ({src_out, dst_in} !== e) begin
            bad++;
            $display("FAIL sb_order got src=%h dst=%h required src=%h dst=%h",
                     src_out, dst_in, e[47:24], e[23:0]);
          end
        end
      end else begin
        total++;
        if (src_out !== 24'd0 || dst_in !== 24'd0) begin
          bad++;
          $display("FAIL idle_outputs src=%h dst=%h required 0 0", src_out, dst_in);
        end
      end
      err_exp = 1'b0;
      if (req_valid && req_ready) begin
        if (req_src < 5'd24 && req_dst != 24'd0) begin
          oh = 24'd1 << req_src;
          exp_q.push_back({oh, req_dst});
        end else begin
          err_exp = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0; hold = 1'b0;
    repeat (3) tick();
    total++;
    if (src_out !== 24'd0 || dst_in !== 24'd0 || xfer !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs src=%h dst=%h xfer=%b err=%b required all 0", src_out, dst_in, xfer, err);
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags ready=%b busy=%b required 1 0", req_ready, busy);
    end
    clr = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || xfer !== 1'b0) begin
      bad++;
      $display("FAIL post_reset busy=%b xfer=%b required 0 0", busy, xfer);
    end
  endtask

  task automatic test_single(input logic [4:0] s, input logic [23:0] d, input logic [23:0] s_oh);
    req_src = s; req_dst = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    total++;
    if (xfer !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_queued src=%0d xfer=%b busy=%b required 0 1", s, xfer, busy);
    end
    tick();
    total++;
    if (xfer !== 1'b1 || src_out !== s_oh || dst_in !== d) begin
      bad++;
      $display("FAIL single_issue xfer=%b src=%h dst=%h required 1 %h %h", xfer, src_out, dst_in, s_oh, d);
    end
    tick();
    total++;
    if (xfer !== 1'b0 || src_out !== 24'd0 || dst_in !== 24'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_done xfer=%b src=%h dst=%h busy=%b required all 0", xfer, src_out, dst_in, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  s [3] = '{5'd5, 5'd16, 5'd0};
    logic [23:0] d [3] = '{24'h000021, 24'h800000, 24'h000007};
    logic [23:0] oh;
    for (int i = 0; i < 3; i++) begin
      req_src = s[i]; req_dst = d[i]; req_valid = 1'b1;
      tick();
      if (i > 0) begin
        oh = 24'd1 << s[i-1];
        total++;
        if (xfer !== 1'b1 || src_out !== oh) begin
          bad++;
          $display("FAIL b2b_issue%0d xfer=%b src=%h required 1 %h", i - 1, xfer, src_out, oh);
        end
      end
    end
    req_valid = 1'b0;
    tick();
    oh = 24'd1 << s[2];
    total++;
    if (xfer !== 1'b1 || src_out !== oh || dst_in !== d[2]) begin
      bad++;
      $display("FAIL b2b_last xfer=%b src=%h dst=%h required 1 %h %h", xfer, src_out, dst_in, oh, d[2]);
    end
    tick();
    total++;
    if (xfer !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle xfer=%b busy=%b required 0 0", xfer, busy);
    end
  endtask

  task automatic test_full();
    logic [4:0]  s [5] = '{5'd1, 5'd2, 5'd5, 5'd17, 5'd23};
    logic [23:0] d [5] = '{24'h000002, 24'h000004, 24'h040000, 24'h000001, 24'h800000};
    logic [23:0] oh;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_src = s[i]; req_dst = d[i]; req_valid = 1'b1;
      total++;
      if (req_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_ready%0d ready=%b required 1", i, req_ready);
      end
      tick();
    end
    req_src = s[4]; req_dst = d[4];
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready ready=%b required 0", req_ready);
    end
    tick();
    tick();
    total++;
    if (req_ready !== 1'b0 || xfer !== 1'b0) begin
      bad++;
      $display("FAIL full_hold ready=%b xfer=%b required 0 0", req_ready, xfer);
    end
    hold = 1'b0;
    tick();
    oh = 24'd1 << s[0];
    total++;
    if (xfer !== 1'b1 || src_out !== oh || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL pushpop_full xfer=%b src=%h ready=%b required 1 %h 1", xfer, src_out, req_ready, oh);
    end
    tick();
    req_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      if (i > 1) tick();
      oh = 24'd1 << s[i];
      total++;
      if (xfer !== 1'b1 || src_out !== oh || dst_in !== d[i]) begin
        bad++;
        $display("FAIL drain%0d xfer=%b src=%h dst=%h required 1 %h %h", i, xfer, src_out, dst_in, oh, d[i]);
      end
    end
    tick();
    total++;
    if (xfer !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_idle xfer=%b busy=%b required 0 0", xfer, busy);
    end
  endtask

  task automatic test_invalid();
    hold = 1'b1;
    req_src = 5'd7; req_dst = 24'h000001; req_valid = 1'b1;
    tick();
    req_src = 5'd27; req_dst = 24'h000001;
    tick();
    total++;
    if (err !== 1'b1 || xfer !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL inv_src err=%b xfer=%b ready=%b required 1 0 1", err, xfer, req_ready);
    end
    req_src = 5'd4; req_dst = 24'h000000;
    tick();
    total++;
    if (err !== 1'b1 || xfer !== 1'b0) begin
      bad++;
      $display("FAIL inv_dst err=%b xfer=%b required 1 0", err, xfer);
    end
    req_valid = 1'b0;
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL inv_pulse_end err=%b required 0", err);
    end
    hold = 1'b0;
    tick();
    total++;
    if (xfer !== 1'b1 || src_out !== 24'h000080) begin
      bad++;
      $display("FAIL inv_keep xfer=%b src=%h required 1 000080", xfer, src_out);
    end
    tick();
    total++;
    if (xfer !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL inv_count xfer=%b busy=%b required 0 0", xfer, busy);
    end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_src = 5'(8 + i); req_dst = 24'd1 << i; req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    hold = 1'b0;
    tick();
    total++;
    if (xfer !== 1'b1 || src_out !== 24'h000100) begin
      bad++;
      $display("FAIL mid_active xfer=%b src=%h required 1 000100", xfer, src_out);
    end
    #2;
    clr = 1'b1;
    #1;
    total++;
    if (xfer !== 1'b0 || src_out !== 24'd0 || dst_in !== 24'd0 || err !== 1'b0 ||
        req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_clr xfer=%b src=%h dst=%h err=%b ready=%b busy=%b required 0 0 0 0 1 0",
               xfer, src_out, dst_in, err, req_ready, busy);
    end
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (xfer !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL stale%0d xfer=%b busy=%b required 0 0", i, xfer, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(5'd3, 24'h000010, 24'h000008);
    test_single(5'd20, 24'h300001, 24'h100000);
    test_back_to_back();
    test_full();
    test_invalid();
    test_reset_mid();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover pending=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
